// File: rtl/dir_queue.sv
// Turn queue for the snake heading: key presses are edge-detected, filtered against the newest pending
// heading, buffered in a 2-entry FIFO and released one per game tick.
module dir_queue #(
  parameter logic [1:0] INIT_DIR = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       tick,
  input  logic       running,
  output logic [1:0] dir,
  output logic [1:0] count,
  output logic       drop
);

  logic [3:0] key_d,   key_q;
  logic [1:0] dir_d,   dir_q;
  logic [1:0] count_d, count_q;
  logic [1:0] fifo0_d, fifo0_q;
  logic [1:0] fifo1_d, fifo1_q;
  logic       drop_d,  drop_q;

  logic [3:0] press;
  logic       has_press;
  logic [1:0] cand;
  logic [1:0] tail;
  logic       reject;
  logic       accept;
  logic       pop;

  // Press detection and filtering against the newest pending heading
  always_comb begin
    key_d     = {up, down, left, right};
    press     = key_d & ~key_q;
    has_press = |press;
    cand      = 2'b00;
    if (press[3])      cand = 2'b00;
    else if (press[2]) cand = 2'b01;
    else if (press[1]) cand = 2'b10;
    else if (press[0]) cand = 2'b11;

    if (count_q == 2'd2)      tail = fifo1_q;
    else if (count_q == 2'd1) tail = fifo0_q;
    else                      tail = dir_q;

    // Equal and opposite headings are exactly the ones sharing the axis bit.
    reject = (cand[1] == tail[1]);
    accept = running & has_press & ~reject;
    pop    = running & tick & (count_q != 2'd0);
  end

  // Queue update: pop into dir and push at tail can happen on the same edge
  always_comb begin
    dir_d   = dir_q;
    count_d = count_q;
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    drop_d  = 1'b0;

    if (!running) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (accept) begin
            fifo0_d = cand;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (pop) begin
            dir_d = fifo0_q;
            if (accept) fifo0_d = cand;
            else        count_d = 2'd0;
          end else if (accept) begin
            fifo1_d = cand;
            count_d = 2'd2;
          end
        end
        default: begin
          if (pop) begin
            dir_d   = fifo0_q;
            fifo0_d = fifo1_q;
            if (accept) fifo1_d = cand;
            else        count_d = 2'd1;
          end else if (accept) begin
            drop_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q   <= 4'b0000;
      dir_q   <= INIT_DIR;
      count_q <= 2'd0;
      fifo0_q <= 2'b00;
      fifo1_q <= 2'b00;
      drop_q  <= 1'b0;
    end else begin
      key_q   <= key_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      fifo0_q <= fifo0_d;
      fifo1_q <= fifo1_d;
      drop_q  <= drop_d;
    end
  end

  assign dir   = dir_q;
  assign count = count_q;
  assign drop  = drop_q;

endmodule
